// File: rtl/fan_battery_ctrl.sv
// fan_battery_ctrl: fan speed stepping, battery drain/charge bookkeeping,
// empty detection and motor PWM for the fan board. Every output is registered.
module fan_battery_ctrl #(
  parameter int INIT_LEVEL    = 99,
  parameter int DRAIN_T1      = 600,
  parameter int DRAIN_T2      = 300,
  parameter int DRAIN_T3      = 150,
  parameter int CHARGE_T      = 200,
  parameter int EMPTY_RELEASE = 5,
  parameter int PWM_PERIOD    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_speed,
  input  logic       key_off,
  input  logic       charger_in,
  output logic [1:0] fan_state,
  output logic [7:0] battery_level,
  output logic       battery_empty,
  output logic       fan_pwm
);

  typedef enum logic [1:0] {
    FAN_OFF  = 2'd0,
    FAN_LOW  = 2'd1,
    FAN_MID  = 2'd2,
    FAN_HIGH = 2'd3
  } fan_t;

  fan_t        fan_q, fan_d;
  logic [1:0]  speed_sync, off_sync, chg_sync;
  logic        speed_prev, off_prev, chg_prev;
  logic        speed_ev, off_ev, charging, chg_change;
  logic [15:0] cnt_q, cnt_d, period_m1;
  logic        counting, wrap, drain_to_zero;
  logic [7:0]  level_q, level_d;
  logic        empty_q, empty_d;
  logic [15:0] pwm_cnt, duty_q, duty_sel, duty_now;

  // Bring the asynchronous keys and charger into the clock domain and keep the previous synchronised values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_sync <= 2'b00;
      off_sync   <= 2'b00;
      chg_sync   <= 2'b00;
      speed_prev <= 1'b0;
      off_prev   <= 1'b0;
      chg_prev   <= 1'b0;
    end else begin
      speed_sync <= {speed_sync[0], key_speed};
      off_sync   <= {off_sync[0], key_off};
      chg_sync   <= {chg_sync[0], charger_in};
      speed_prev <= speed_sync[1];
      off_prev   <= off_sync[1];
      chg_prev   <= chg_sync[1];
    end
  end

  assign speed_ev   = speed_sync[1] & ~speed_prev;
  assign off_ev     = off_sync[1] & ~off_prev;
  assign charging   = chg_sync[1];
  assign chg_change = chg_sync[1] ^ chg_prev;

  // Pick the count period for the current mode and decide whether the level moves this cycle
  always_comb begin
    period_m1     = 16'd0;
    counting      = 1'b0;
    if (charging) begin
      period_m1 = 16'(CHARGE_T - 1);
      counting  = 1'b1;
    end else begin
      case (fan_q)
        FAN_LOW:  begin period_m1 = 16'(DRAIN_T1 - 1); counting = 1'b1; end
        FAN_MID:  begin period_m1 = 16'(DRAIN_T2 - 1); counting = 1'b1; end
        FAN_HIGH: begin period_m1 = 16'(DRAIN_T3 - 1); counting = 1'b1; end
        default:  begin period_m1 = 16'd0; counting = 1'b0; end
      endcase
    end
    // A mode change discards the partial count from the old mode, so it never produces a step
    wrap          = counting && !chg_change && (cnt_q >= period_m1);
    drain_to_zero = wrap && !charging && (level_q == 8'd1);
  end

  // Level and empty-flag next values; the flag sets as the level hits 0 and clears only by charging
  always_comb begin
    level_d = level_q;
    empty_d = empty_q;
    if (wrap) begin
      if (charging) begin
        if (level_q < 8'd99) level_d = level_q + 8'd1;
        if (empty_q && (level_d >= 8'(EMPTY_RELEASE))) empty_d = 1'b0;
      end else if (level_q != 8'd0) begin
        level_d = level_q - 8'd1;
      end
    end
    if (drain_to_zero) empty_d = 1'b1;
  end

  // Fan speed next state: emptying and off both force OFF, otherwise a speed event steps 1-2-3-1
  always_comb begin
    fan_d = fan_q;
    if (drain_to_zero || off_ev || empty_q) begin
      fan_d = FAN_OFF;
    end else if (speed_ev) begin
      case (fan_q)
        FAN_OFF:  fan_d = FAN_LOW;
        FAN_LOW:  fan_d = FAN_MID;
        FAN_MID:  fan_d = FAN_HIGH;
        FAN_HIGH: fan_d = FAN_LOW;
        default:  fan_d = FAN_OFF;
      endcase
    end
  end

  // Shared drain/charge counter restarts on any speed or charger change and idles at 0 when nothing runs
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if ((fan_d != fan_q) || chg_change || !counting || wrap) cnt_d = 16'd0;
  end

  // Fan state, level, empty flag and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_q   <= FAN_OFF;
      level_q <= 8'(INIT_LEVEL);
      empty_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      fan_q   <= fan_d;
      level_q <= level_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fan_state     = fan_q;
  assign battery_level = level_q;
  assign battery_empty = empty_q;

  // Duty for the current speed, adopted only at a period start so each period is whole
  always_comb begin
    case (fan_q)
      FAN_LOW:  duty_sel = 16'd4;
      FAN_MID:  duty_sel = 16'd7;
      FAN_HIGH: duty_sel = 16'(PWM_PERIOD);
      default:  duty_sel = 16'd0;
    endcase
    duty_now = (pwm_cnt == 16'd0) ? duty_sel : duty_q;
  end

  // Free-running PWM counter and registered motor drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 16'd0;
      duty_q  <= 16'd0;
      fan_pwm <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt >= 16'(PWM_PERIOD - 1)) ? 16'd0 : pwm_cnt + 16'd1;
      duty_q  <= duty_now;
      fan_pwm <= (pwm_cnt < duty_now);
    end
  end

endmodule

// File: tb/tb_fan_battery_ctrl.sv
// tb_fan_battery_ctrl: directed scenarios with a cycle-stamped scoreboard of expected outputs.
module tb_fan_battery_ctrl;

  localparam int F_FAN   = 0;
  localparam int F_LVL   = 1;
  localparam int F_EMPTY = 2;
  localparam int F_PWM   = 3;
  localparam int F_HITS  = 4;

  typedef struct {
    int    due;
    string tag;
    int    field;
    int    val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_speed, key_off, charger_in;
  logic [1:0] fan_state;
  logic [7:0] battery_level;
  logic       battery_empty;
  logic       fan_pwm;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pwm_hits = 0;
  logic chg_on = 1'b0;

  fan_battery_ctrl #(
    .INIT_LEVEL(3), .DRAIN_T1(4), .DRAIN_T2(3), .DRAIN_T3(2),
    .CHARGE_T(5), .EMPTY_RELEASE(5), .PWM_PERIOD(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_speed(key_speed), .key_off(key_off),
    .charger_in(charger_in), .fan_state(fan_state), .battery_level(battery_level),
    .battery_empty(battery_empty), .fan_pwm(fan_pwm)
  );

  // 10-time-unit system clock
  always #5 clk = ~clk;

  function automatic void expectAt(input int due, input string tag, input int field, input int val);
    exp_t e;
    e.due = due; e.tag = tag; e.field = field; e.val = val;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] observe(input int field);
    case (field)
      F_FAN:   return {30'd0, fan_state};
      F_LVL:   return {24'd0, battery_level};
      F_EMPTY: return {31'd0, battery_empty};
      F_PWM:   return {31'd0, fan_pwm};
      default: return 32'(pwm_hits);
    endcase
  endfunction

  task automatic checkOutput();
    int i;
    exp_t e;
    logic [31:0] obs;
    i = 0;
    while (i < sb.size()) begin
      e = sb[i];
      if (e.due == cyc) begin
        obs = observe(e.field);
        total++;
        assert (obs === $unsigned(e.val)) else begin
          bad++;
          $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", e.tag, cyc, obs, e.val);
        end
        sb.delete(i);
      end else if (e.due < cyc) begin
        total++;
        bad++;
        $error("[TB] FAIL %s expired due=%0d cyc=%0d observed=none expected=%0d", e.tag, e.due, cyc, e.val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic applyStimulus(input logic spd, input logic off);
    key_speed  = spd;
    key_off    = off;
    charger_in = chg_on;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic pressSpeed(input int old_v, input int new_v, input int gap);
    int k;
    k = cyc;
    expectAt(k + 2, "key_latency_old", F_FAN, old_v);
    expectAt(k + 3, "key_latency_new", F_FAN, new_v);
    applyStimulus(1'b1, 1'b0);
    stepN(1);
    applyStimulus(1'b0, 1'b0);
    stepN(gap);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    chg_on = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #2;
    expectAt(cyc, "rst_fan", F_FAN, 0);
    expectAt(cyc, "rst_level", F_LVL, 3);
    expectAt(cyc, "rst_empty", F_EMPTY, 0);
    expectAt(cyc, "rst_pwm", F_PWM, 0);
    checkOutput();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic measurePwm(input int expected);
    stepN(20);
    pwm_hits = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (fan_pwm === 1'b1) pwm_hits++;
    end
    expectAt(cyc, "pwm_duty", F_HITS, expected);
    checkOutput();
  endtask

  // Directed scenario sequence
  initial begin
    int k;
    int seq[5] = '{1, 2, 3, 1, 2};
    int prev_v;

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Speed stepping while charging so the battery never empties
    doReset();
    chg_on = 1'b1;
    applyStimulus(1'b0, 1'b0);
    stepN(3);
    prev_v = 0;
    for (int i = 0; i < 5; i++) begin
      pressSpeed(prev_v, seq[i], 4);
      prev_v = seq[i];
    end
    k = cyc;
    expectAt(k + 2, "hold_old", F_FAN, 2);
    expectAt(k + 3, "hold_step", F_FAN, 3);
    expectAt(k + 20, "hold_single", F_FAN, 3);
    applyStimulus(1'b1, 1'b0);
    stepN(20);
    applyStimulus(1'b0, 1'b0);
    expectAt(cyc + 5, "hold_release", F_FAN, 3);
    stepN(5);

    // Off priority over a simultaneous speed event
    pressSpeed(3, 1, 4);
    pressSpeed(1, 2, 4);
    k = cyc;
    expectAt(k + 2, "off_prio_old", F_FAN, 2);
    expectAt(k + 3, "off_prio", F_FAN, 0);
    expectAt(k + 8, "off_prio_stay", F_FAN, 0);
    applyStimulus(1'b1, 1'b1);
    stepN(1);
    applyStimulus(1'b0, 1'b0);
    stepN(7);

    // Drain to empty at high speed
    doReset();
    pressSpeed(0, 1, 1);
    pressSpeed(1, 2, 1);
    pressSpeed(2, 3, 1);
    expectAt(8, "drain_l3", F_LVL, 3);
    expectAt(9, "drain_l2", F_LVL, 2);
    expectAt(10, "drain_l2_hold", F_LVL, 2);
    expectAt(11, "drain_l1", F_LVL, 1);
    expectAt(12, "drain_pre_empty", F_EMPTY, 0);
    expectAt(12, "drain_pre_fan", F_FAN, 3);
    expectAt(13, "drain_l0", F_LVL, 0);
    expectAt(13, "drain_empty", F_EMPTY, 1);
    expectAt(13, "drain_fan_off", F_FAN, 0);
    stepN(9);
    pressSpeed(0, 0, 4);
    expectAt(cyc, "empty_lvl_hold", F_LVL, 0);
    expectAt(cyc, "empty_flag_hold", F_EMPTY, 1);
    checkOutput();

    // Charge from empty, release the flag at level 5, run the fan while charging, saturate
    chg_on = 1'b1;
    applyStimulus(1'b0, 1'b0);
    expectAt(27, "chg_l0", F_LVL, 0);
    expectAt(28, "chg_l1", F_LVL, 1);
    expectAt(47, "chg_l4", F_LVL, 4);
    expectAt(47, "chg_still_empty", F_EMPTY, 1);
    expectAt(48, "chg_l5", F_LVL, 5);
    expectAt(48, "chg_release", F_EMPTY, 0);
    stepN(28);
    pressSpeed(0, 1, 4);
    expectAt(55, "chg_fan_l5", F_LVL, 5);
    expectAt(56, "chg_fan_l6", F_LVL, 6);
    expectAt(56, "chg_fan_state", F_FAN, 1);
    stepN(3);
    expectAt(520, "sat_l98", F_LVL, 98);
    expectAt(521, "sat_l99", F_LVL, 99);
    expectAt(560, "sat_hold", F_LVL, 99);
    expectAt(560, "sat_fan", F_FAN, 1);
    stepN(504);

    // PWM duty per speed, charging so speed stays put
    doReset();
    chg_on = 1'b1;
    applyStimulus(1'b0, 1'b0);
    stepN(3);
    measurePwm(0);
    pressSpeed(0, 1, 4);
    measurePwm(4);
    pressSpeed(1, 2, 4);
    measurePwm(7);
    pressSpeed(2, 3, 4);
    measurePwm(10);

    // Reset mid-count with fan low, counter at 2 and level 2
    doReset();
    pressSpeed(0, 1, 4);
    expectAt(6, "mid_l3", F_LVL, 3);
    expectAt(7, "mid_l2", F_LVL, 2);
    expectAt(9, "mid_pre_rst_lvl", F_LVL, 2);
    expectAt(9, "mid_pre_rst_fan", F_FAN, 1);
    stepN(4);
    doReset();
    pressSpeed(0, 1, 4);
    expectAt(6, "post_rst_l3", F_LVL, 3);
    expectAt(7, "post_rst_l2", F_LVL, 2);
    stepN(2);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $error("[TB] FAIL %s unchecked due=%0d observed=none expected=%0d", e.tag, e.due, e.val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
